gtbtg: RTL and testbench
========================

// Module: gtbtg
// PURPOSE
//   Registered, bidirectional Gray-code converter of width N. mode=0 converts
//   binary->Gray; mode=1 converts Gray->binary. Intended for datapaths such as
//   async-FIFO pointer handling and encoder interfaces, where one block serves
//   both directions. Single clock domain. Output is registered, 1-cycle latency.
// PARAMETERS
//   N       8    data width in bits; legal range N >= 1
// PORTS
//   clk     in   1    system clock; all state updates on rising edge
//   rst_n   in   1    asynchronous, active-low reset
//   en      in   1    conversion enable; sampled on clk rising edge
//   mode    in   1    0 = binary->Gray, 1 = Gray->binary; sampled with x
//   x       in   N    input word (binary if mode=0, Gray if mode=1)
//   y       out  N    registered converted word
//   y_valid out  1    high when y holds a conversion of the previous cycle's x
// BEHAVIOUR
//   Clocking and reset:
//   - One clock (clk). Reset is asynchronous and active-low (rst_n); polarity
//     and synchronicity are fixed.
//   - rst_n low: y = 0 and y_valid = 0 immediately, independent of clk.
//     Both hold until the first rising edge after rst_n deasserts.
//   Conversion, on each rising edge with rst_n high:
//   - en=1, mode=0: y <= x ^ (x >> 1), i.e. y[N-1]=x[N-1] and
//     y[i]=x[i+1]^x[i] for i<N-1. Sets y_valid <= 1.
//   - en=1, mode=1: y[N-1] <= x[N-1]; y[i] <= y_b[i+1]^x[i], down to i=0,
//     where y_b is the combinational binary result (prefix XOR from MSB).
//     Sets y_valid <= 1.
//   - en=0: y <= 0 and y_valid <= 0. The output is cleared, not held.
//   Latency and timing:
//   - Latency is exactly 1 cycle from sampled inputs to y. No backpressure,
//     no handshake. A new input is accepted every cycle.
//   - mode may change on any cycle. Each cycle's output reflects only that
//     cycle's sampled mode/x. There is no history, no pipeline carry-over.
//   Width and corner cases:
//   - Pure combinational XOR network feeding an N-bit register. No arithmetic
//     carries, no overflow. All N bits are always defined.
//   - N=1: y = x in both modes.
//   - Round-trip identity: G2B(B2G(v)) == v and B2G(G2B(v)) == v for all v.
//   - X/Z on x while en=1 propagates to y. No sanitising is performed.
//   - rst_n asserted mid-stream: outputs clear asynchronously. The first valid
//     output is produced 1 cycle after the first enabled edge post-reset.
// TESTING (N=8; y checked one cycle after inputs applied)
//   - Reset: rst_n=0 with en=1, x=8'hFF -> y=8'h00, y_valid=0 without a clock
//     edge. Release rst_n -> valid output on the next edge.
//   - B2G, mode=0, en=1: x = 0,1,5,10,255 -> y = 8'h00,8'h01,8'h07,8'h0F,8'h80,
//     with y_valid=1 on each.
//   - G2B, mode=1, en=1: x = 00,01,03,02,80,FF -> y = 00,01,02,03,FF,AA.
//   - Mode toggle every cycle with x=8'h03: mode 0 -> y=8'h02; mode 1 ->
//     y=8'h02. Confirms no cross-cycle coupling.
//   - Disable: en=0 with x=8'h55 -> y=8'h00, y_valid=0 next edge. Re-enable
//     with mode=0, x=8'h55 -> y=8'h7F.
//   - Exhaustive round-trip: for all 256 values v, B2G then G2B -> v. Also
//     check adjacent B2G outputs for v, v+1 (mod 256) differ in exactly 1 bit.

Source files
------------

// File: rtl/gtbtg_if.sv
// ============================================================================
// gtbtg_if : data bundle for the registered Gray-code converter
// Rev 1.0
// ============================================================================
`default_nettype none

interface gtbtg_if #(
  parameter int N = 8
);
  logic         en;
  logic         mode;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         y_valid;

  modport master (output en, output mode, output x, input y, input y_valid);
  modport slave  (input en, input mode, input x, output y, output y_valid);
endinterface

`default_nettype wire

// File: rtl/gtbtg.sv
// ============================================================================
// gtbtg : registered bidirectional Gray converter (mode 0 B2G, mode 1 G2B)
// Rev 1.0
// ============================================================================
`default_nettype none

module gtbtg #(
  parameter int N = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  gtbtg_if.slave  bus
);

  logic [N-1:0] w_b2g;
  logic [N-1:0] w_g2b;
  logic [N-1:0] y_d;
  logic [N-1:0] y_q;
  logic         y_valid_d;
  logic         y_valid_q;

  assign w_b2g = bus.x ^ (bus.x >> 1);

  // Each binary bit is the XOR of all Gray bits at or above it; a reduction
  // per bit avoids a rippled self-referencing vector.
  always_comb begin
    w_g2b = '0;
    for (int i = 0; i < N; i++) begin
      w_g2b[i] = ^(bus.x >> i);
    end
  end

  always_comb begin
    y_d       = '0;
    y_valid_d = 1'b0;
    if (bus.en) begin
      y_d       = bus.mode ? w_g2b : w_b2g;
      y_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_gtbtg.sv
// ============================================================================
// tb_gtbtg : scoreboard bench for gtbtg (N=8)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gtbtg;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [8:0] sb_q[$];

  gtbtg_if #(.N(8)) bus ();

  gtbtg #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one input word, push its expectation, then pop and compare after the edge.
  task automatic step(input logic e, input logic m, input logic [7:0] xv,
                      input logic [7:0] ey, input logic ev, input string tag);
    logic [8:0] exp;
    @(negedge clk);
    bus.en   = e;
    bus.mode = m;
    bus.x    = xv;
    sb_q.push_back({ev, ey});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      check({tag, "_y"},     {24'd0, bus.y},  {24'd0, exp[7:0]});
      check({tag, "_valid"}, {31'd0, bus.y_valid}, {31'd0, exp[8]});
    end
  endtask

  logic [7:0] b2g_x [5] = '{8'h00, 8'h01, 8'h05, 8'h0A, 8'hFF};
  logic [7:0] b2g_y [5] = '{8'h00, 8'h01, 8'h07, 8'h0F, 8'h80};
  logic [7:0] g2b_x [6] = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h80, 8'hFF};
  logic [7:0] g2b_y [6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF, 8'hAA};

  initial begin
    logic [7:0] gray_obs;
    logic [7:0] gray_first;
    logic [7:0] gray_prev;
    logic [7:0] v8;
    n_cmp = 0;
    n_err = 0;

    rst_n    = 1'b0;
    bus.en   = 1'b1;
    bus.mode = 1'b0;
    bus.x    = 8'hFF;
    #3;
    check("rst_y_noedge",     {24'd0, bus.y}, 32'h0);
    check("rst_valid_noedge", {31'd0, bus.y_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_y_held",     {24'd0, bus.y}, 32'h0);
    check("rst_valid_held", {31'd0, bus.y_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'hFF, 8'h80, 1'b1, "post_rst");

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, b2g_x[i], b2g_y[i], 1'b1, "b2g");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, g2b_x[i], g2b_y[i], 1'b1, "g2b");

    for (int i = 0; i < 4; i++) step(1'b1, 1'(i % 2), 8'h03, 8'h02, 1'b1, "toggle");

    step(1'b0, 1'b0, 8'h55, 8'h00, 1'b0, "disable");
    step(1'b1, 1'b0, 8'h55, 8'h7F, 1'b1, "reenable");

    // Asynchronous reset between edges must clear without waiting for a clock.
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_y",     {24'd0, bus.y}, 32'h0);
    check("midrst_valid", {31'd0, bus.y_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 8'hFF, 8'hAA, 1'b1, "after_midrst");

    gray_first = 8'h00;
    gray_prev  = 8'h00;
    for (int v = 0; v < 256; v++) begin
      v8 = 8'(v);
      step(1'b1, 1'b0, v8, v8 ^ (v8 >> 1), 1'b1, "rt_b2g");
      gray_obs = bus.y;
      step(1'b1, 1'b1, gray_obs, v8, 1'b1, "rt_g2b");
      if (v == 0) gray_first = gray_obs;
      else        check("adj_1bit", $countones(gray_obs ^ gray_prev), 32'd1);
      gray_prev = gray_obs;
    end
    check("adj_wrap", $countones(gray_prev ^ gray_first), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
